// File: rtl/master_interface.sv
// Serial-bus initiator: serialises a latched read/write request into address and
// write-data frames, collects serial read data and the slave response.
module master_interface #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [1:0]        slave_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              error,
  output logic              busy,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              master_en,
  output logic              addr_out,
  output logic              w_data_out,
  input  logic              r_data_in,
  input  logic [1:0]        response_in
);

  localparam int AF_W = ADDR_W + 4;
  localparam int DF_W = DATA_W + 1;
  localparam int CW   = $clog2(AF_W);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, ADDR, WDATA, RDATA, WAIT_RESP, SPLIT_WAIT, DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                started_q, started_d;
  logic                rw_q, rw_d;
  logic [1:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                error_q, error_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                bus_req_q, bus_req_d;
  logic                master_en_q, master_en_d;
  logic                addr_out_q, addr_out_d;
  logic                w_data_out_q, w_data_out_d;

  logic [AF_W-1:0]     addr_frame_s;
  logic [DF_W-1:0]     data_frame_s;
  logic [CW-1:0]       abit_s;
  logic [CW-1:0]       dbit_s;

  assign addr_frame_s = {1'b1, rw_q, sel_q, addr_q};
  assign data_frame_s = {1'b1, wdata_q};

  // State and output registers; all outputs clear asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      started_q    <= 1'b0;
      rw_q         <= 1'b0;
      sel_q        <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      shift_q      <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      bus_req_q    <= 1'b0;
      master_en_q  <= 1'b0;
      addr_out_q   <= 1'b0;
      w_data_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      started_q    <= started_d;
      rw_q         <= rw_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      shift_q      <= shift_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      bus_req_q    <= bus_req_d;
      master_en_q  <= master_en_d;
      addr_out_q   <= addr_out_d;
      w_data_out_q <= w_data_out_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    started_d = started_q;
    rw_d      = rw_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    shift_d   = shift_q;
    rdata_d   = rdata_q;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          rw_d    = rw;
          sel_d   = slave_sel;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        cnt_d = '0;
        if (bus_grant) state_d = ADDR;
        else           state_d = REQ;
      end
      ADDR: begin
        if (!bus_grant) begin
          state_d = REQ;
          cnt_d   = '0;
        end else if (cnt_q == CW'(AF_W - 1)) begin
          cnt_d     = '0;
          tmo_d     = '0;
          started_d = 1'b0;
          state_d   = rw_q ? WDATA : RDATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WDATA: begin
        if (!bus_grant) begin
          state_d = REQ;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DATA_W)) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = WAIT_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RDATA: begin
        if (tmo_q == TMO_LAST) begin
          state_d = DONE;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (!started_q) begin
            started_d = r_data_in;
          end else begin
            shift_d = {shift_q[DATA_W-2:0], r_data_in};
            if (cnt_q == CW'(DATA_W - 1)) begin
              cnt_d   = '0;
              tmo_d   = '0;
              state_d = WAIT_RESP;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      WAIT_RESP: begin
        case (response_in)
          2'b01: begin
            state_d = DONE;
            rdata_d = rw_q ? rdata_q : shift_q;
          end
          2'b11: begin
            state_d = DONE;
            error_d = 1'b1;
          end
          2'b10: begin
            state_d = SPLIT_WAIT;
            cnt_d   = '0;
          end
          default: begin
            if (tmo_q == TMO_LAST) begin
              state_d = DONE;
              error_d = 1'b1;
            end else begin
              tmo_d = tmo_q + TW'(1);
            end
          end
        endcase
      end
      // First cycle releases the bus; afterwards re-request and resume on grant.
      SPLIT_WAIT: begin
        if (cnt_q == '0) begin
          cnt_d = CW'(1);
        end else if (bus_grant) begin
          cnt_d     = '0;
          started_d = 1'b0;
          state_d   = rw_q ? WAIT_RESP : RDATA;
        end else begin
          state_d = SPLIT_WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every port comes straight from a flop.
  always_comb begin
    abit_s       = CW'(AF_W - 1) - cnt_d;
    dbit_s       = CW'(DATA_W) - cnt_d;
    busy_d       = 1'b0;
    bus_req_d    = 1'b0;
    master_en_d  = 1'b0;
    addr_out_d   = 1'b0;
    w_data_out_d = 1'b0;
    done_d       = 1'b0;
    case (state_d)
      REQ: begin
        busy_d    = 1'b1;
        bus_req_d = 1'b1;
      end
      ADDR: begin
        busy_d      = 1'b1;
        bus_req_d   = 1'b1;
        master_en_d = 1'b1;
        addr_out_d  = addr_frame_s[abit_s];
      end
      WDATA: begin
        busy_d       = 1'b1;
        bus_req_d    = 1'b1;
        master_en_d  = 1'b1;
        w_data_out_d = data_frame_s[dbit_s];
      end
      RDATA, WAIT_RESP: begin
        busy_d    = 1'b1;
        bus_req_d = 1'b1;
      end
      SPLIT_WAIT: begin
        busy_d    = 1'b1;
        bus_req_d = (cnt_d != '0);
      end
      DONE:    done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  assign rdata      = rdata_q;
  assign done       = done_q;
  assign error      = error_q;
  assign busy       = busy_q;
  assign bus_req    = bus_req_q;
  assign master_en  = master_en_q;
  assign addr_out   = addr_out_q;
  assign w_data_out = w_data_out_q;

endmodule

// File: tb/tb_master_interface.sv
// Directed bench for master_interface: frame streams, read/split/error/timeout
// flows, grant loss and asynchronous reset.
module tb_master_interface;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rw;
  logic [1:0]  slave_sel;
  logic [11:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        done, error, busy, bus_req, bus_grant, master_en;
  logic        addr_out, w_data_out, r_data_in;
  logic [1:0]  response_in;

  int errors = 0;
  int checks = 0;

  master_interface #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .slave_sel(slave_sel),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .error(error),
    .busy(busy), .bus_req(bus_req), .bus_grant(bus_grant), .master_en(master_en),
    .addr_out(addr_out), .w_data_out(w_data_out), .r_data_in(r_data_in),
    .response_in(response_in)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks the address frame (and optional write frame) bit by bit.
  task automatic check_frame(input logic [15:0] af, input logic do_w, input logic [8:0] wf);
    for (int i = 0; i < 16; i++) begin
      chk("addr_bit", 32'(addr_out), 32'(af[15-i]));
      chk("addr_men", 32'(master_en), 32'(1'b1));
      chk("addr_wline", 32'(w_data_out), 32'(1'b0));
      step();
    end
    if (do_w) begin
      for (int i = 0; i < 9; i++) begin
        chk("wdata_bit", 32'(w_data_out), 32'(wf[8-i]));
        chk("wdata_men", 32'(master_en), 32'(1'b1));
        chk("wdata_aline", 32'(addr_out), 32'(1'b0));
        step();
      end
    end
  endtask

  task automatic send_rdata(input logic [7:0] d);
    r_data_in = 1'b1;
    step();
    for (int i = 7; i >= 0; i--) begin
      r_data_in = d[i];
      chk("rd_men", 32'(master_en), 32'(1'b0));
      step();
    end
    r_data_in = 1'b0;
  endtask

  task automatic launch(input logic w, input logic [1:0] s, input logic [11:0] a, input logic [7:0] d);
    rw = w; slave_sel = s; addr = a; wdata = d; start = 1'b1;
    step();
    start = 1'b0;
    chk("req_busreq", 32'(bus_req), 32'(1'b1));
    chk("req_busy", 32'(busy), 32'(1'b1));
    step();
  endtask

  initial begin
    logic [15:0] af;
    reset = 1'b0; start = 1'b0; rw = 1'b0; slave_sel = 2'b00; addr = 12'h000;
    wdata = 8'h00; bus_grant = 1'b1; r_data_in = 1'b0; response_in = 2'b00;
    step();
    step();
    chk("rst_rdata", 32'(rdata), 32'(8'h00));
    chk("rst_done", 32'(done), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_busreq", 32'(bus_req), 32'(1'b0));
    chk("rst_men", 32'(master_en), 32'(1'b0));
    reset = 1'b1;
    step();

    // Write with garbage inputs and a second start while busy.
    rw = 1'b1; slave_sel = 2'd2; addr = 12'h0A5; wdata = 8'h3C; start = 1'b1;
    step();
    rw = 1'b0; slave_sel = 2'd0; addr = 12'hFFF; wdata = 8'h00;
    chk("w_busreq", 32'(bus_req), 32'(1'b1));
    chk("w_busy", 32'(busy), 32'(1'b1));
    chk("w_men_req", 32'(master_en), 32'(1'b0));
    step();
    start = 1'b0;
    check_frame(16'hE0A5, 1'b1, 9'h13C);
    chk("w_wait_done", 32'(done), 32'(1'b0));
    chk("w_wait_men", 32'(master_en), 32'(1'b0));
    step();
    step();
    response_in = 2'b01;
    step();
    response_in = 2'b00;
    chk("w_done", 32'(done), 32'(1'b1));
    chk("w_err", 32'(error), 32'(1'b0));
    chk("w_done_busy", 32'(busy), 32'(1'b0));
    chk("w_done_busreq", 32'(bus_req), 32'(1'b0));
    step();
    chk("w_idle_done", 32'(done), 32'(1'b0));

    // Read slave 1 addr 0xFFF; stray response during RDATA must be ignored.
    launch(1'b0, 2'd1, 12'hFFF, 8'h00);
    check_frame(16'h9FFF, 1'b0, 9'h000);
    chk("r_men", 32'(master_en), 32'(1'b0));
    response_in = 2'b11;
    send_rdata(8'hA5);
    response_in = 2'b01;
    step();
    response_in = 2'b00;
    chk("r_done", 32'(done), 32'(1'b1));
    chk("r_err", 32'(error), 32'(1'b0));
    chk("r_rdata", 32'(rdata), 32'(8'hA5));
    step();

    // Split read: bus released one cycle, resumed without address resend.
    launch(1'b0, 2'd3, 12'h123, 8'h00);
    check_frame(16'hB123, 1'b0, 9'h000);
    send_rdata(8'h00);
    response_in = 2'b10;
    step();
    response_in = 2'b00;
    bus_grant = 1'b0;
    chk("s_rel_busreq", 32'(bus_req), 32'(1'b0));
    chk("s_rel_busy", 32'(busy), 32'(1'b1));
    step();
    chk("s_rereq1", 32'(bus_req), 32'(1'b1));
    step();
    chk("s_rereq2", 32'(bus_req), 32'(1'b1));
    chk("s_nodone", 32'(done), 32'(1'b0));
    bus_grant = 1'b1;
    step();
    chk("s_men", 32'(master_en), 32'(1'b0));
    chk("s_aline", 32'(addr_out), 32'(1'b0));
    send_rdata(8'h5A);
    response_in = 2'b01;
    step();
    response_in = 2'b00;
    chk("s_done", 32'(done), 32'(1'b1));
    chk("s_err", 32'(error), 32'(1'b0));
    chk("s_rdata", 32'(rdata), 32'(8'h5A));
    step();

    // Write answered ERROR.
    launch(1'b1, 2'd0, 12'h001, 8'hFF);
    check_frame(16'hC001, 1'b1, 9'h1FF);
    response_in = 2'b11;
    step();
    response_in = 2'b00;
    chk("e_done", 32'(done), 32'(1'b1));
    chk("e_err", 32'(error), 32'(1'b1));
    chk("e_rdata", 32'(rdata), 32'(8'h5A));
    step();

    // Grant lost at address bit 5, then a response that never comes.
    af = 16'hD800;
    launch(1'b1, 2'd1, 12'h800, 8'h81);
    for (int i = 0; i < 5; i++) begin
      chk("g_bit", 32'(addr_out), 32'(af[15-i]));
      step();
    end
    chk("g_bit5", 32'(addr_out), 32'(af[10]));
    bus_grant = 1'b0;
    step();
    chk("g_men", 32'(master_en), 32'(1'b0));
    chk("g_aline", 32'(addr_out), 32'(1'b0));
    chk("g_busreq", 32'(bus_req), 32'(1'b1));
    step();
    chk("g_men_hold", 32'(master_en), 32'(1'b0));
    bus_grant = 1'b1;
    step();
    check_frame(af, 1'b1, 9'h181);
    for (int i = 0; i < 16; i++) begin
      chk("t_wait", 32'(done), 32'(1'b0));
      step();
    end
    chk("t_done", 32'(done), 32'(1'b1));
    chk("t_err", 32'(error), 32'(1'b1));
    step();

    // Asynchronous reset during write-data bit 4.
    launch(1'b1, 2'd2, 12'h0A5, 8'h3C);
    for (int i = 0; i < 20; i++) step();
    chk("x_men_pre", 32'(master_en), 32'(1'b1));
    reset = 1'b0;
    #1;
    chk("x_men", 32'(master_en), 32'(1'b0));
    chk("x_busreq", 32'(bus_req), 32'(1'b0));
    chk("x_busy", 32'(busy), 32'(1'b0));
    chk("x_rdata", 32'(rdata), 32'(8'h00));
    chk("x_wline", 32'(w_data_out), 32'(1'b0));
    chk("x_done", 32'(done), 32'(1'b0));
    step();
    step();
    reset = 1'b1;
    step();
    chk("x_idle_busy", 32'(busy), 32'(1'b0));

    launch(1'b0, 2'd2, 12'h456, 8'h00);
    check_frame(16'hA456, 1'b0, 9'h000);
    send_rdata(8'hC3);
    response_in = 2'b01;
    step();
    response_in = 2'b00;
    chk("p_done", 32'(done), 32'(1'b1));
    chk("p_err", 32'(error), 32'(1'b0));
    chk("p_rdata", 32'(rdata), 32'(8'hC3));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
